forwarding_scoreboard: RTL and testbench

Parametrised successor to the combinational forwarding controller. It keeps its own shift-register scoreboard of in-flight destination writes for the stages after EX. From that scoreboard it produces per-operand forward selects for the instruction in EX, a load-use stall request, and a saturating stall-cycle counter. It sits beside the ID/EX barrier and drives the operand forward muxes and the pipeline stall/bubble logic.

---
 rtl/forwarding_scoreboard_pkg.sv | 24 ++
 rtl/forwarding_scoreboard_src_select.sv | 50 +++++
 rtl/forwarding_scoreboard.sv | 92 +++++++++
 tb/tb_forwarding_scoreboard.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/forwarding_scoreboard_pkg.sv
// Shared types and helpers for the EX-stage forwarding scoreboard.
// Record layout is {valid, is_load, dest}; select 0 means "read the regfile".
package forwarding_scoreboard_pkg;

    localparam int LC3B_REG_W = 3;

    typedef logic [LC3B_REG_W-1:0] lc3b_reg;

    typedef struct packed {
        logic    valid;
        logic    is_load;
        lc3b_reg dest;
    } lc3b_fwd_rec;

    typedef enum logic [0:0] {
        FWD_REGFILE = 1'b0
    } fwd_sel_base_e;

    // Width of one operand's forward select: regfile plus one code per stage.
    function automatic int fwd_sel_w(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/forwarding_scoreboard_src_select.sv
// Priority match of one EX operand against the in-flight record array.
// Youngest matching stage wins; an unready load winner raises load_hazard instead.
module fwd_src_select #(
    parameter int NUM_STAGES = 2,
    parameter int REG_W      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SELW       = 2
) (
    input  logic                        ex_valid,
    input  logic                        src_valid,
    input  logic [REG_W-1:0]            src_reg,
    input  logic [NUM_STAGES-1:0]       rec_valid,
    input  logic [NUM_STAGES-1:0]       rec_load,
    input  logic [NUM_STAGES*REG_W-1:0] rec_dest,
    output logic [SELW-1:0]             sel,
    output logic                        load_hazard
);

    logic hit;
    logic hit_load;
    int   hit_idx;

    always_comb begin
        hit      = 1'b0;
        hit_load = 1'b0;
        hit_idx  = 0;
        // Scan oldest to youngest so the lowest matching index is left standing.
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (ex_valid && src_valid && rec_valid[j] &&
                rec_dest[j*REG_W +: REG_W] == src_reg) begin
                hit      = 1'b1;
                hit_load = rec_load[j];
                hit_idx  = j;
            end
        end
    end

    always_comb begin
        sel         = '0;
        load_hazard = 1'b0;
        if (hit) begin
            if (hit_load && hit_idx < LOAD_LAT) begin
                load_hazard = 1'b1;
            end else begin
                sel = SELW'(hit_idx + 1);
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Tracks in-flight destination writes after EX and derives forward selects,
// the load-use stall request and a saturating stall-cycle counter.
module forwarding_scoreboard
    import forwarding_scoreboard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int REG_W      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     advance,
    input  logic                                     flush,
    input  logic                                     ex_valid,
    input  logic [NUM_SRC-1:0]                       ex_src_valid,
    input  logic [NUM_SRC*REG_W-1:0]                 ex_src_reg,
    input  logic                                     ex_dest_valid,
    input  logic [REG_W-1:0]                         ex_dest_reg,
    input  logic                                     ex_is_load,
    input  logic                                     perf_clear,
    output logic [NUM_SRC*fwd_sel_w(NUM_STAGES)-1:0] fwd_sel,
    output logic                                     stall_req,
    output logic [CNT_W-1:0]                         stall_count
);

    localparam int SELW = fwd_sel_w(NUM_STAGES);

    logic [NUM_STAGES-1:0]       rec_valid_reg;
    logic [NUM_STAGES-1:0]       rec_load_reg;
    logic [NUM_STAGES*REG_W-1:0] rec_dest_reg;
    logic [NUM_SRC-1:0]          src_hazard;
    logic                        rec0_valid_next;
    logic [CNT_W-1:0]            stall_count_reg;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_src_select #(
                .NUM_STAGES (NUM_STAGES),
                .REG_W      (REG_W),
                .LOAD_LAT   (LOAD_LAT),
                .SELW       (SELW)
            ) u_sel (
                .ex_valid    (ex_valid),
                .src_valid   (ex_src_valid[gi]),
                .src_reg     (ex_src_reg[gi*REG_W +: REG_W]),
                .rec_valid   (rec_valid_reg),
                .rec_load    (rec_load_reg),
                .rec_dest    (rec_dest_reg),
                .sel         (fwd_sel[gi*SELW +: SELW]),
                .load_hazard (src_hazard[gi])
            );
        end
    endgenerate

    // A squashed instruction never needs to wait for its operands.
    assign stall_req = (|src_hazard) & ~flush;

    // A stalled EX instruction enters MEM as a bubble; it re-issues from EX.
    assign rec0_valid_next = ex_valid & ex_dest_valid & ~flush & ~stall_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rec_valid_reg <= '0;
            rec_load_reg  <= '0;
            rec_dest_reg  <= '0;
        end else if (advance) begin
            for (int j = NUM_STAGES - 1; j >= 1; j--) begin
                rec_valid_reg[j]              <= rec_valid_reg[j-1];
                rec_load_reg[j]               <= rec_load_reg[j-1];
                rec_dest_reg[j*REG_W +: REG_W] <= rec_dest_reg[(j-1)*REG_W +: REG_W];
            end
            rec_valid_reg[0]       <= rec0_valid_next;
            rec_load_reg[0]        <= ex_is_load;
            rec_dest_reg[0 +: REG_W] <= ex_dest_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_count_reg <= '0;
        end else if (perf_clear) begin
            stall_count_reg <= '0;
        end else if (stall_req && advance && stall_count_reg != {CNT_W{1'b1}}) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: forwarding priority, load-use stall,
// memory-stall hold, flush, counter saturation/clear and mid-hazard reset.
module tb_forwarding_scoreboard;

    localparam int NUM_SRC    = 2;
    localparam int NUM_STAGES = 2;
    localparam int REG_W      = 3;
    localparam int LOAD_LAT   = 1;
    localparam int CNT_W      = 4;
    localparam int SELW       = 2;

    logic                       clk;
    logic                       reset_n;
    logic                       advance;
    logic                       flush;
    logic                       ex_valid;
    logic [NUM_SRC-1:0]         ex_src_valid;
    logic [NUM_SRC*REG_W-1:0]   ex_src_reg;
    logic                       ex_dest_valid;
    logic [REG_W-1:0]           ex_dest_reg;
    logic                       ex_is_load;
    logic                       perf_clear;
    logic [NUM_SRC*SELW-1:0]    fwd_sel;
    logic                       stall_req;
    logic [CNT_W-1:0]           stall_count;

    int n_cmp = 0;
    int n_err = 0;

    forwarding_scoreboard #(
        .NUM_SRC    (NUM_SRC),
        .NUM_STAGES (NUM_STAGES),
        .REG_W      (REG_W),
        .LOAD_LAT   (LOAD_LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .advance       (advance),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_src_valid  (ex_src_valid),
        .ex_src_reg    (ex_src_reg),
        .ex_dest_valid (ex_dest_valid),
        .ex_dest_reg   (ex_dest_reg),
        .ex_is_load    (ex_is_load),
        .perf_clear    (perf_clear),
        .fwd_sel       (fwd_sel),
        .stall_req     (stall_req),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-12s observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive the EX slot: two source operands plus an optional destination.
    task automatic set_ex(input logic v, input logic s0v, input logic [2:0] s0,
                          input logic s1v, input logic [2:0] s1,
                          input logic dv, input logic [2:0] d, input logic ld);
        ex_valid      = v;
        ex_src_valid  = {s1v, s0v};
        ex_src_reg    = {s1, s0};
        ex_dest_valid = dv;
        ex_dest_reg   = d;
        ex_is_load    = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int sel0, input int sel1,
                           input int stall, input int cnt);
        #1;
        chk({tag, ".sel0"}, 32'(fwd_sel[1:0]), 32'(sel0));
        chk({tag, ".sel1"}, 32'(fwd_sel[3:2]), 32'(sel1));
        chk({tag, ".stall"}, 32'(stall_req), 32'(stall));
        chk({tag, ".cnt"}, 32'(stall_count), 32'(cnt));
    endtask

    initial begin
        reset_n = 1'b0; advance = 1'b1; flush = 1'b0; perf_clear = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset_n = 1'b1;
        chk_out("reset", 0, 0, 0, 0);

        // 1: ADD R1 then a reader of R1/R2
        set_ex(1, 0, 0, 0, 0, 1, 3'd1, 0);
        tick();
        set_ex(1, 1, 3'd1, 1, 3'd2, 0, 0, 0);
        chk_out("t1_fwd", 1, 0, 0, 0);
        tick();

        // 2: two R3 writers back-to-back, youngest wins
        set_ex(1, 0, 0, 0, 0, 1, 3'd3, 0);
        tick();
        tick();
        set_ex(1, 1, 3'd3, 1, 3'd3, 0, 0, 0);
        chk_out("t2_young", 1, 1, 0, 0);
        tick();
        chk_out("t2_old", 2, 2, 0, 0);

        // 3: LDR R4 then immediate use
        set_ex(1, 0, 0, 0, 0, 1, 3'd4, 1);
        tick();
        set_ex(1, 0, 0, 1, 3'd4, 1, 3'd6, 0);
        chk_out("t3_stall", 0, 0, 1, 0);
        tick();
        chk_out("t3_after", 0, 2, 0, 1);
        tick();

        // 4: load-use while memory stalls for three cycles
        set_ex(1, 0, 0, 0, 0, 1, 3'd2, 1);
        tick();
        set_ex(1, 1, 3'd2, 0, 0, 0, 0, 0);
        advance = 1'b0;
        chk_out("t4_hold0", 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("t4_hold", 0, 0, 1, 1);
        end
        advance = 1'b1;
        tick();
        chk_out("t4_go", 2, 0, 0, 2);

        // 5: flushed writer is not recorded; flush masks a live hazard
        set_ex(1, 0, 0, 0, 0, 1, 3'd5, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_ex(1, 1, 3'd5, 1, 3'd5, 0, 0, 0);
        chk_out("t5_squash", 0, 0, 0, 2);
        set_ex(1, 0, 0, 0, 0, 1, 3'd7, 1);
        tick();
        set_ex(1, 1, 3'd7, 0, 0, 0, 0, 0);
        flush = 1'b1;
        chk_out("t5_flushst", 0, 0, 0, 2);
        flush = 1'b0;
        chk_out("t5_live", 0, 0, 1, 2);

        // 6: drive the counter into saturation (2 + 13 = 15), then past it
        for (int k = 0; k < 13; k++) begin
            tick();
            set_ex(1, 0, 0, 0, 0, 1, 3'd7, 1);
            tick();
            set_ex(1, 1, 3'd7, 0, 0, 0, 0, 0);
        end
        chk_out("t6_full", 0, 0, 1, 15);
        for (int k = 0; k < 3; k++) begin
            tick();
            set_ex(1, 0, 0, 0, 0, 1, 3'd7, 1);
            tick();
            set_ex(1, 1, 3'd7, 0, 0, 0, 0, 0);
        end
        chk_out("t6_sat", 0, 0, 1, 15);
        perf_clear = 1'b1;
        tick();
        perf_clear = 1'b0;
        chk_out("t6_clear", 2, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 1, 3'd7, 1);
        tick();
        set_ex(1, 1, 3'd7, 1, 3'd7, 0, 0, 0);
        chk_out("t6_prerst", 0, 0, 1, 0);
        tick();
        set_ex(1, 0, 0, 0, 0, 1, 3'd7, 1);
        tick();
        set_ex(1, 1, 3'd7, 1, 3'd7, 0, 0, 0);
        chk_out("t6_hz2", 0, 0, 1, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_out("t6_rst", 0, 0, 0, 0);

        // Destination with ex_valid low must not be recorded
        set_ex(0, 0, 0, 0, 0, 1, 3'd3, 0);
        tick();
        set_ex(1, 1, 3'd3, 0, 0, 0, 0, 0);
        chk_out("inv_dest", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
